// File: rtl/cpu_seq_ctrl_if.sv
// Data-memory request bus between the sequencer and data memory.
// Ports: master drives req/we/addr/wdata; slave drives rdata/ready.
interface cpu_seq_ctrl_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [15:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT, owns the PC.
// Ports: clk, rst (async high), imem_data, pc, ir, reg_ra*/reg_rd*,
//   alu_s1/s2, alu_dest, alu_pc_new, dmem (bus master), reg_we/wa/wdata,
//   halted, mem_err, state. Macro CPU_SEQ_PERF_EN adds cycle_cnt and
//   retired_cnt counters.
module cpu_seq_ctrl #(
  parameter logic [15:0] PC_RESET     = 16'h0000,
  parameter logic [5:0]  HALT_OPCODE  = 6'h3F,
  parameter int unsigned DMEM_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    imem_data,
  output logic [15:0]    pc,
  output logic [31:0]    ir,
  output logic [4:0]     reg_ra1,
  output logic [4:0]     reg_ra2,
  input  logic [31:0]    reg_rd1,
  input  logic [31:0]    reg_rd2,
  output logic [31:0]    alu_s1,
  output logic [31:0]    alu_s2,
  input  logic [31:0]    alu_dest,
  input  logic [15:0]    alu_pc_new,
  cpu_seq_ctrl_if.master dmem,
  output logic           reg_we,
  output logic [4:0]     reg_wa,
  output logic [31:0]    reg_wdata,
  output logic           halted,
  output logic           mem_err,
  output logic [2:0]     state
`ifdef CPU_SEQ_PERF_EN
  ,
  output logic [31:0]    cycle_cnt,
  output logic [31:0]    retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } st_e;

  localparam int TW  = (DMEM_TIMEOUT > 1) ?
                       $clog2(DMEM_TIMEOUT + 1) : 1;
  localparam int TW1 = TW + 1;

  st_e         st_q;
  logic [15:0] pc_q;
  logic [15:0] pcn_q;
  logic [31:0] ir_q;
  logic [31:0] s1_q;
  logic [31:0] s2_q;
  logic        req_q;
  logic        we_q;
  logic        reg_we_q;
  logic [4:0]  reg_wa_q;
  logic [31:0] reg_wdata_q;
  logic        halted_q;
  logic        mem_err_q;
  logic [TW-1:0] cnt_q;

  logic [5:0]  op;
  logic        is_mem;
  logic        is_br;
  logic        wb_en;
  logic [4:0]  wa_sel;
  logic [TW:0] cnt_inc;
  logic        tmo_hit;

  assign op      = ir_q[31:26];
  assign is_mem  = (op == 6'd5) || (op == 6'd6);
  assign is_br   = (op >= 6'd7) && (op <= 6'd15);
  assign cnt_inc = {1'b0, cnt_q} + TW1'(1);
  // A zero timeout never matches, so MEM waits forever.
  assign tmo_hit = (DMEM_TIMEOUT != 0) &&
                   (cnt_inc == TW1'(DMEM_TIMEOUT));

  always_comb begin
    wb_en  = 1'b0;
    wa_sel = ir_q[20:16];
    unique case (1'b1)
      (op == 6'd0): begin
        wb_en  = 1'b1;
        wa_sel = ir_q[15:11];
      end
      (op >= 6'd1 && op <= 6'd4): begin
        wb_en  = 1'b1;
        wa_sel = ir_q[25:21];
      end
      (op == 6'd16): begin
        wb_en  = 1'b1;
        wa_sel = ir_q[20:16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= S_FETCH;
      pc_q        <= PC_RESET;
      pcn_q       <= '0;
      ir_q        <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_wa_q    <= '0;
      reg_wdata_q <= '0;
      halted_q    <= 1'b0;
      mem_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      reg_we_q <= 1'b0;
      unique case (st_q)
        S_FETCH: begin
          ir_q <= imem_data;
          st_q <= S_DECODE;
        end
        S_DECODE: begin
          s1_q <= reg_rd1;
          s2_q <= reg_rd2;
          if (op == HALT_OPCODE) begin
            st_q     <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            st_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          pcn_q       <= alu_pc_new;
          reg_wdata_q <= alu_dest;
          if (is_mem) begin
            st_q  <= S_MEM;
            req_q <= 1'b1;
            we_q  <= (op == 6'd6);
            cnt_q <= '0;
          end else begin
            st_q     <= S_WB;
            reg_we_q <= wb_en;
            reg_wa_q <= wa_sel;
          end
        end
        S_MEM: begin
          if (dmem.dmem_ready) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            cnt_q <= '0;
            st_q  <= S_WB;
            if (op == 6'd5) begin
              reg_we_q    <= 1'b1;
              reg_wa_q    <= ir_q[20:16];
              reg_wdata_q <= dmem.dmem_rdata;
            end
          end else if (tmo_hit) begin
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            mem_err_q <= 1'b1;
            halted_q  <= 1'b1;
            st_q      <= S_HALT;
          end else begin
            cnt_q <= cnt_inc[TW-1:0];
          end
        end
        S_WB: begin
          // Branch/jump only redirects when the target differs.
          if (is_br && (pcn_q != pc_q))
            pc_q <= pcn_q;
          else
            pc_q <= pc_q + 16'd1;
          st_q <= S_FETCH;
        end
        S_HALT: st_q <= S_HALT;
        default: begin
          st_q  <= S_FETCH;
          req_q <= 1'b0;
          we_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_SEQ_PERF_EN
  logic [31:0] cyc_q;
  logic [31:0] ret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if ((st_q != S_HALT) && (cyc_q != '1))
        cyc_q <= cyc_q + 32'd1;
      if ((st_q == S_WB) && (ret_q != '1))
        ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;
`endif

  assign pc              = pc_q;
  assign ir              = ir_q;
  assign reg_ra1         = ir_q[25:21];
  assign reg_ra2         = ir_q[20:16];
  assign alu_s1          = s1_q;
  assign alu_s2          = s2_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = s1_q[15:0] + ir_q[15:0];
  assign dmem.dmem_wdata = s2_q;
  assign reg_we          = reg_we_q;
  assign reg_wa          = reg_wa_q;
  assign reg_wdata       = reg_wdata_q;
  assign halted          = halted_q;
  assign mem_err         = mem_err_q;
  assign state           = st_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Bench for cpu_seq_ctrl: random instruction streams vs a reference model.
// Environment supplies regfile, adder ALU, imem and a latency-controlled dmem.
module tb_cpu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_data = '0;
  logic [15:0] pc;
  logic [31:0] ir;
  logic [4:0]  reg_ra1, reg_ra2;
  logic [31:0] reg_rd1, reg_rd2;
  logic [31:0] alu_s1, alu_s2;
  logic [31:0] alu_dest;
  logic [15:0] alu_pc_new;
  logic        reg_we;
  logic [4:0]  reg_wa;
  logic [31:0] reg_wdata;
  logic        halted, mem_err;
  logic [2:0]  state;
`ifdef CPU_SEQ_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  cpu_seq_ctrl_if mif();

  cpu_seq_ctrl #(.DMEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .imem_data(imem_data),
    .pc(pc), .ir(ir),
    .reg_ra1(reg_ra1), .reg_ra2(reg_ra2),
    .reg_rd1(reg_rd1), .reg_rd2(reg_rd2),
    .alu_s1(alu_s1), .alu_s2(alu_s2),
    .alu_dest(alu_dest), .alu_pc_new(alu_pc_new),
    .dmem(mif),
    .reg_we(reg_we), .reg_wa(reg_wa), .reg_wdata(reg_wdata),
    .halted(halted), .mem_err(mem_err), .state(state)
`ifdef CPU_SEQ_PERF_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  logic [15:0] pcn_drv = '0;
  logic [15:0] mpc;
  int total = 0;
  int bad = 0;

  always_comb begin
    reg_rd1 = rf[reg_ra1];
    reg_rd2 = rf[reg_ra2];
  end
  assign alu_dest   = alu_s1 + alu_s2;
  assign alu_pc_new = pcn_drv;

  function automatic logic m_we(input logic [5:0] op);
    return (op <= 6'd5) || (op == 6'd16);
  endfunction

  function automatic logic [4:0] m_wa(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    if (op == 6'd0) return ins[15:11];
    if (op >= 6'd1 && op <= 6'd4) return ins[25:21];
    return ins[20:16];
  endfunction

  function automatic logic [15:0] m_pc(input logic [5:0] op,
                                       input logic [15:0] p,
                                       input logic [15:0] t);
    if (op >= 6'd7 && op <= 6'd15 && t != p) return t;
    return p + 16'd1;
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    imem_data = '0;
    mif.dmem_ready = 1'b0;
    mif.dmem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mpc = 16'h0000;
  endtask

  // Runs one instruction from FETCH until FETCH or HALT, recording bus
  // activity. dly = MEM cycle in which ready rises (0 = never).
  task automatic run_instr(
    input  logic [31:0] ins, input int dly, input logic [31:0] rdata,
    output int cyc, output int nwe,
    output logic [4:0] wa, output logic [31:0] wd,
    output int nreq, output logic [15:0] addr, output logic we,
    output logic [31:0] wdat, output logic stable);
    cyc = 0; nwe = 0; nreq = 0;
    wa = '0; wd = '0; addr = '0; we = 1'b0; wdat = '0;
    stable = 1'b1;
    imem_data = ins;
    mif.dmem_rdata = rdata;
    while (cyc < 40) begin
      if (mif.dmem_req) begin
        nreq++;
        if (nreq == 1) begin
          addr = mif.dmem_addr;
          we   = mif.dmem_we;
          wdat = mif.dmem_wdata;
        end else if (mif.dmem_addr !== addr || mif.dmem_we !== we ||
                     mif.dmem_wdata !== wdat) begin
          stable = 1'b0;
        end
        mif.dmem_ready = (nreq == dly);
      end else begin
        mif.dmem_ready = 1'b0;
      end
      if (reg_we) begin
        nwe++;
        wa = reg_wa;
        wd = reg_wdata;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (state == 3'd0 || state == 3'd5) break;
    end
    mif.dmem_ready = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if (state !== 3'd0 || pc !== 16'h0 || ir !== 32'h0) begin
      bad++;
      $display("FAIL reset_core: state=%0d pc=%0h ir=%0h want 0 0 0",
               state, pc, ir);
    end
    total++;
    if (alu_s1 !== 32'h0 || alu_s2 !== 32'h0) begin
      bad++;
      $display("FAIL reset_ops: s1=%0h s2=%0h want 0 0", alu_s1, alu_s2);
    end
    total++;
    if (mif.dmem_req !== 1'b0 || mif.dmem_we !== 1'b0 ||
        reg_we !== 1'b0) begin
      bad++;
      $display("FAIL reset_strobes: req=%b we=%b rwe=%b want 0",
               mif.dmem_req, mif.dmem_we, reg_we);
    end
    total++;
    if (reg_wa !== 5'd0 || reg_wdata !== 32'h0 ||
        halted !== 1'b0 || mem_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_misc: wa=%0h wd=%0h h=%b e=%b want 0",
               reg_wa, reg_wdata, halted, mem_err);
    end
  endtask

  task automatic test_alu;
    logic [31:0] ins, wd, wdat, ew;
    logic [4:0]  wa;
    logic [15:0] addr, ep;
    logic [5:0]  op;
    logic        we, stable;
    int          cyc, nwe, nreq, enwe;
    do_reset;
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    for (int i = 0; i < 30; i++) begin
      if (i == 0) begin
        ins = {6'd0, 5'd1, 5'd2, 5'd3, 11'd0};
      end else begin
        op = 6'($urandom_range(0, 62));
        if (op == 6'd5 || op == 6'd6) op = 6'd0;
        ins = {op, 26'($urandom)};
      end
      op = ins[31:26];
      pcn_drv = (i % 4 == 1) ? mpc : 16'($urandom);
      enwe = m_we(op) ? 1 : 0;
      ew = rf[ins[25:21]] + rf[ins[20:16]];
      ep = m_pc(op, mpc, pcn_drv);
      run_instr(ins, 0, 32'h0, cyc, nwe, wa, wd,
                nreq, addr, we, wdat, stable);
      total++;
      if (cyc !== 4 || nreq !== 0) begin
        bad++;
        $display("FAIL alu_lat op=%0d: cyc=%0d req=%0d want 4 0",
                 op, cyc, nreq);
      end
      total++;
      if (nwe !== enwe) begin
        bad++;
        $display("FAIL alu_we op=%0d: got %0d want %0d", op, nwe, enwe);
      end
      if (enwe == 1) begin
        total++;
        if (wa !== m_wa(ins) || wd !== ew) begin
          bad++;
          $display("FAIL alu_wb op=%0d: wa=%0d wd=%0h want %0d %0h",
                   op, wa, wd, m_wa(ins), ew);
        end
      end
      total++;
      if (pc !== ep) begin
        bad++;
        $display("FAIL alu_pc op=%0d: got %0h want %0h", op, pc, ep);
      end
      mpc = ep;
    end
  endtask

  task automatic test_mem;
    logic [31:0] ins, wd, wdat, rd;
    logic [4:0]  wa;
    logic [15:0] addr, ea;
    logic        we, stable, isw;
    int          cyc, nwe, nreq, dly;
    do_reset;
    for (int r = 0; r < 32; r++) rf[r] = $urandom;
    rf[1] = 32'h10;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        ins = {6'd5, 5'd1, 5'd9, 16'h0004};
        dly = 3;
      end else begin
        ins = {($urandom_range(0, 1) == 1) ? 6'd6 : 6'd5, 26'($urandom)};
        dly = $urandom_range(1, 4);
      end
      isw = (ins[31:26] == 6'd6);
      ea = rf[ins[25:21]][15:0] + ins[15:0];
      rd = $urandom;
      run_instr(ins, dly, rd, cyc, nwe, wa, wd,
                nreq, addr, we, wdat, stable);
      total++;
      if (cyc !== 4 + dly || nreq !== dly) begin
        bad++;
        $display("FAIL mem_lat: cyc=%0d req=%0d want %0d %0d",
                 cyc, nreq, 4 + dly, dly);
      end
      total++;
      if (addr !== ea || we !== isw || wdat !== rf[ins[20:16]]) begin
        bad++;
        $display("FAIL mem_bus: a=%0h we=%b d=%0h want %0h %b %0h",
                 addr, we, wdat, ea, isw, rf[ins[20:16]]);
      end
      total++;
      if (stable !== 1'b1) begin
        bad++;
        $display("FAIL mem_hold: fields changed while waiting");
      end
      total++;
      if (isw ? (nwe !== 0) :
          (nwe !== 1 || wa !== ins[20:16] || wd !== rd)) begin
        bad++;
        $display("FAIL mem_wb sw=%b: n=%0d wa=%0d wd=%0h want rd %0h",
                 isw, nwe, wa, wd, rd);
      end
      total++;
      if (pc !== mpc + 16'd1) begin
        bad++;
        $display("FAIL mem_pc: got %0h want %0h", pc, mpc + 16'd1);
      end
      mpc = mpc + 16'd1;
    end
  endtask

  task automatic test_branch;
    logic [31:0] wd, wdat;
    logic [4:0]  wa;
    logic [15:0] addr, ep;
    logic [15:0] tgt [4];
    logic [31:0] seq [4];
    logic        we, stable;
    int          cyc, nwe, nreq;
    tgt[0] = 16'h0020; seq[0] = {6'd8, 26'h0};
    tgt[1] = 16'h0005; seq[1] = {6'd8, 26'h0};
    tgt[2] = 16'hFFFF; seq[2] = {6'd12, 26'h0};
    tgt[3] = 16'h1234; seq[3] = {6'd20, 26'h0};
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        do_reset;
        pcn_drv = 16'h0;
        for (int j = 0; j < 5; j++) begin
          run_instr({6'd17, 26'h0}, 0, 32'h0, cyc, nwe, wa, wd,
                    nreq, addr, we, wdat, stable);
          mpc = mpc + 16'd1;
        end
        total++;
        if (pc !== 16'd5) begin
          bad++;
          $display("FAIL br_setup: pc=%0h want 5", pc);
        end
      end
      pcn_drv = tgt[k];
      ep = m_pc(seq[k][31:26], mpc, tgt[k]);
      run_instr(seq[k], 0, 32'h0, cyc, nwe, wa, wd,
                nreq, addr, we, wdat, stable);
      total++;
      if (pc !== ep || cyc !== 4 || nwe !== 0) begin
        bad++;
        $display("FAIL br_pc%0d: pc=%0h cyc=%0d we=%0d want %0h 4 0",
                 k, pc, cyc, nwe, ep);
      end
      mpc = ep;
    end
  endtask

  task automatic test_timeout;
    logic [31:0] wd, wdat;
    logic [4:0]  wa;
    logic [15:0] addr, p0;
    logic        we, stable;
    int          cyc, nwe, nreq;
    do_reset;
    run_instr({6'd6, 5'd3, 5'd4, 16'h0040}, 0, 32'h0, cyc, nwe, wa, wd,
              nreq, addr, we, wdat, stable);
    total++;
    if (cyc !== 7 || nreq !== 4 || nwe !== 0) begin
      bad++;
      $display("FAIL tmo_seq: cyc=%0d req=%0d we=%0d want 7 4 0",
               cyc, nreq, nwe);
    end
    total++;
    if (mem_err !== 1'b1 || halted !== 1'b1 || mif.dmem_req !== 1'b0 ||
        state !== 3'd5) begin
      bad++;
      $display("FAIL tmo_flags: e=%b h=%b req=%b st=%0d want 1 1 0 5",
               mem_err, halted, mif.dmem_req, state);
    end
    p0 = mpc;
    repeat (6) @(negedge clk);
    total++;
    if (pc !== p0 || halted !== 1'b1 || mem_err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_park: pc=%0h h=%b e=%b want %0h 1 1",
               pc, halted, mem_err, p0);
    end
  endtask

  task automatic test_halt;
    logic [31:0] wd, wdat;
    logic [4:0]  wa;
    logic [15:0] addr;
    logic        we, stable;
    int          cyc, nwe, nreq, wes;
    do_reset;
    run_instr({6'd17, 26'h0}, 0, 32'h0, cyc, nwe, wa, wd,
              nreq, addr, we, wdat, stable);
    mpc = mpc + 16'd1;
    run_instr({6'h3F, 26'h155}, 0, 32'h0, cyc, nwe, wa, wd,
              nreq, addr, we, wdat, stable);
    total++;
    if (cyc !== 2 || halted !== 1'b1 || state !== 3'd5) begin
      bad++;
      $display("FAIL halt_entry: cyc=%0d h=%b st=%0d want 2 1 5",
               cyc, halted, state);
    end
    wes = 0;
    for (int j = 0; j < 8; j++) begin
      if (reg_we || mif.dmem_req) wes++;
      @(negedge clk);
    end
    total++;
    if (pc !== mpc || wes !== 0 || mem_err !== 1'b0) begin
      bad++;
      $display("FAIL halt_park: pc=%0h strobes=%0d e=%b want %0h 0 0",
               pc, wes, mem_err, mpc);
    end
  endtask

  task automatic test_rst_in_mem;
    logic [31:0] wd, wdat;
    logic [4:0]  wa;
    logic [15:0] addr;
    logic        we, stable;
    int          cyc, nwe, nreq;
    do_reset;
    run_instr({6'd17, 26'h0}, 0, 32'h0, cyc, nwe, wa, wd,
              nreq, addr, we, wdat, stable);
    imem_data = {6'd5, 5'd2, 5'd3, 16'h0008};
    mif.dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (mif.dmem_req !== 1'b1 || state !== 3'd3) begin
      bad++;
      $display("FAIL rst_mem_pre: req=%b st=%0d want 1 3",
               mif.dmem_req, state);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (mif.dmem_req !== 1'b0 || pc !== 16'h0 || state !== 3'd0) begin
      bad++;
      $display("FAIL rst_mem_abort: req=%b pc=%0h st=%0d want 0 0 0",
               mif.dmem_req, pc, state);
    end
    @(negedge clk);
    rst = 1'b0;
    mpc = 16'h0;
  endtask

`ifdef CPU_SEQ_PERF_EN
  task automatic test_perf;
    logic [31:0] wd, wdat;
    logic [4:0]  wa;
    logic [15:0] addr;
    logic        we, stable;
    int          cyc, nwe, nreq;
    do_reset;
    for (int j = 0; j < 3; j++)
      run_instr({6'd0, 5'd1, 5'd2, 5'd3, 11'd0}, 0, 32'h0, cyc, nwe,
                wa, wd, nreq, addr, we, wdat, stable);
    total++;
    if (retired_cnt !== 32'd3 || cycle_cnt !== 32'd12) begin
      bad++;
      $display("FAIL perf: ret=%0d cyc=%0d want 3 12",
               retired_cnt, cycle_cnt);
    end
  endtask
`endif

  initial begin
    for (int r = 0; r < 32; r++) rf[r] = '0;
    mif.dmem_ready = 1'b0;
    mif.dmem_rdata = '0;
    test_reset;
    test_alu;
    test_mem;
    test_branch;
    test_timeout;
    test_halt;
    test_rst_in_mem;
`ifdef CPU_SEQ_PERF_EN
    test_perf;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Multicycle sequencing controller for the single-issue CPU datapath. It replaces delay-based timing with a clocked FSM that steps each instruction through fetch, register read, ALU execute, data-memory access and writeback. It drives the register file, ALU operand and data-memory ports, and owns the PC. Data memory uses a req/ready handshake, so memory latency can vary.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset.
HALT_OPCODE, 6'h3F, opcode that parks the FSM in HALT.
DMEM_TIMEOUT, 255, max cycles in MEM waiting for dmem_ready before the FSM aborts; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
imem_data  in  32  instruction word at pc (combinational instruction memory).
pc  out  16  program counter.
ir  out  32  latched instruction; drives ALU opcode/funct/shamt/const/jump fields.
reg_ra1, reg_ra2  out  5  register read addresses (ir[25:21], ir[20:16]).
reg_rd1, reg_rd2  in  32  register read data.
alu_s1, alu_s2  out  32  latched operands to ALU.
alu_dest  in  32  ALU result.
alu_pc_new  in  16  ALU-computed next PC for branch/jump.
dmem_req  out  1  data memory request.
dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
dmem_addr  out  16  alu_s1[15:0] + ir[15:0], modulo 2^16.
dmem_wdata  out  32  store data (alu_s2).
dmem_rdata  in  32  load data; valid when dmem_ready = 1.
dmem_ready  in  1  completes the current request.
reg_we  out  1  register write strobe, one cycle.
reg_wa  out  5  register write address.
reg_wdata  out  32  register write data.
halted  out  1  FSM is in HALT.
mem_err  out  1  sticky flag, set when DMEM_TIMEOUT expires.
state  out  3  current FSM state, for debug.

Behaviour:
- Reset (async): state=FETCH, pc=PC_RESET, ir=0, alu_s1=alu_s2=0, all strobes 0, reg_wa=0, reg_wdata=0, halted=0, mem_err=0, timeout counter=0.
- Reset asserted mid-operation aborts any in-flight memory request; dmem_req drops immediately.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 return to FETCH on the next clock.
- FETCH: ir <= imem_data. Go to DECODE.
- DECODE: reg_ra1/reg_ra2 are decoded from ir. Latch alu_s1 <= reg_rd1 and alu_s2 <= reg_rd2. If ir[31:26]==HALT_OPCODE, go to HALT; otherwise go to EXEC.
- EXEC: latch alu_dest and alu_pc_new into internal registers. Opcode 5 (lw) or 6 (sw) goes to MEM; all other opcodes go to WB.
- MEM: dmem_req=1 and all request fields are held stable until the cycle in which dmem_ready=1.
  - dmem_ready seen: lw latches dmem_rdata and goes to WB; sw goes to WB with no register write.
  - dmem_ready may be high in the first MEM cycle; the minimum MEM duration is 1 cycle.
  - The counter increments each MEM cycle without ready. When it reaches DMEM_TIMEOUT (nonzero), set mem_err, drop dmem_req and go to HALT.
- WB: reg_we is pulsed for one cycle according to the opcode:
  - opcode 0: reg_wa=ir[15:11], data = ALU result.
  - opcodes 1-4: reg_wa=ir[25:21], data = ALU result.
  - opcode 5: reg_wa=ir[20:16], data = load data.
  - opcode 16: reg_wa=ir[20:16], data = ALU result.
  - All other opcodes: reg_we=0.
- WB PC update:
  - Opcodes 7-15: pc <= (latched pc_new != pc) ? latched pc_new : pc+1.
  - All other opcodes: pc <= pc+1.
  - PC wraps modulo 2^16. Opcodes 17-62 execute as no-ops.
  - Go to FETCH.
- Instruction latency: 4 cycles for non-memory instructions; 4 + MEM cycles for lw/sw.
- HALT: halted=1 and all strobes are 0. Only rst exits HALT.

Optional Feature:
Macro: CPU_SEQ_PERF_EN.
- Defined: adds outputs cycle_cnt[31:0] and retired_cnt[31:0], both reset to 0.
  - cycle_cnt increments every clock outside HALT.
  - retired_cnt increments on each WB-to-FETCH transition.
  - Both counters saturate at 32'hFFFFFFFF.
- Undefined: neither port nor logic exists.

Test Plan:
- opcode 0, rs=1 (5), rt=2 (7), rd=3, ALU add -> reg_we pulses 4 cycles after FETCH with reg_wa=3, reg_wdata=12; pc 0->1.
- lw with s1=0x10, const=0x4, ready delayed 3 cycles -> dmem_addr=0x14 held for 3 cycles, dmem_we=0; reg_wa=rt, reg_wdata=dmem_rdata; total latency 7 cycles.
- Branch opcode 8 with alu_pc_new=0x20, pc=5 -> pc=0x20; repeat with alu_pc_new=5 -> pc=6; at pc=0xFFFF non-branch -> pc=0x0000.
- DMEM_TIMEOUT=4, sw with dmem_ready held low -> mem_err=1, halted=1, dmem_req=0 after the 4th MEM cycle, no register write.
- Instruction with opcode 0x3F -> halted=1 from the cycle after DECODE and pc frozen; assert rst in a MEM cycle -> dmem_req=0 immediately, pc=PC_RESET, state=FETCH.
- CPU_SEQ_PERF_EN defined, run 3 add instructions -> retired_cnt=3, cycle_cnt=12.
